// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// muldiv_ctrl: multi-cycle MULTU/DIVU sequencer that borrows the shared 32-bit ALU
// one step per granted cycle. Define MULDIV_SIGNED_EN to add signed MULT/DIV.
// Rev 1.0
// ----------------------------------------------------------------------------
module muldiv_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            ready,
  output logic            done,
  output logic            div_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            alu_req,
  input  logic            alu_gnt,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_control,
  input  logic [XLEN-1:0] alu_result
);

  localparam logic [2:0]       ALU_ADD   = 3'b010;
  localparam logic [2:0]       ALU_SUB   = 3'b110;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

`ifdef MULDIV_SIGNED_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ITER = 2'd1, S_DONE = 2'd2, S_SIGN = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ITER = 2'd1, S_DONE = 2'd2} state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [XLEN-1:0]  hi_q, hi_d;
  logic [XLEN-1:0]  lo_q, lo_d;
  logic [XLEN-1:0]  opnd_q, opnd_d;
  logic             is_div_q, is_div_d;
  logic             dz_q, dz_d;

  logic [XLEN-1:0]  a_in, b_in;
  logic [XLEN-1:0]  div_r;
  logic             mul_carry;

`ifdef MULDIV_SIGNED_EN
  logic sgn_q, sgn_d;
  logic neg_q, neg_d;
  logic neg_hi_q, neg_hi_d;

  // Signed ops iterate on magnitudes; signs are restored in S_SIGN.
  assign a_in = (op[1] & src_a[XLEN-1]) ? -src_a : src_a;
  assign b_in = (op[1] & src_b[XLEN-1]) ? -src_b : src_b;
`else
  logic unused_op_sign;

  assign unused_op_sign = op[1];
  assign a_in           = src_a;
  assign b_in           = src_b;
`endif

  assign div_r     = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
  assign mul_carry = (alu_result < hi_q);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    opnd_d      = opnd_q;
    is_div_d    = is_div_q;
    dz_d        = dz_q;
    alu_req     = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_control = 3'b000;
`ifdef MULDIV_SIGNED_EN
    sgn_d       = sgn_q;
    neg_d       = neg_q;
    neg_hi_d    = neg_hi_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_ITER;
          count_d  = '0;
          hi_d     = '0;
          is_div_d = op[0];
          dz_d     = op[0] & (src_b == '0);
          lo_d     = op[0] ? a_in : b_in;
          opnd_d   = op[0] ? b_in : a_in;
`ifdef MULDIV_SIGNED_EN
          sgn_d    = op[1];
          neg_d    = op[1] & (src_a[XLEN-1] ^ src_b[XLEN-1]);
          neg_hi_d = op[1] & src_a[XLEN-1];
`endif
        end
      end

      S_ITER: begin
        alu_req = 1'b1;
        if (is_div_q) begin
          alu_a       = div_r;
          alu_b       = opnd_q;
          alu_control = ALU_SUB;
        end else begin
          alu_a       = hi_q;
          alu_b       = lo_q[0] ? opnd_q : '0;
          alu_control = ALU_ADD;
        end

        if (alu_gnt) begin
          count_d = count_q + 1'b1;
          if (is_div_q) begin
            // Shifted-out bit set means the partial remainder already exceeds 2^32,
            // so the wrapped subtract result is the true remainder.
            if (hi_q[XLEN-1] | (div_r >= opnd_q)) begin
              hi_d = alu_result;
              lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
              hi_d = div_r;
              lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
          end else begin
            hi_d = {mul_carry, alu_result[XLEN-1:1]};
            lo_d = {alu_result[0], lo_q[XLEN-1:1]};
          end

          if (count_q == LAST_ITER) begin
`ifdef MULDIV_SIGNED_EN
            state_d = sgn_q ? S_SIGN : S_DONE;
`else
            state_d = S_DONE;
`endif
          end
        end
      end

`ifdef MULDIV_SIGNED_EN
      S_SIGN: begin
        state_d = S_DONE;
        if (!is_div_q) begin
          if (neg_q) {hi_d, lo_d} = -{hi_q, lo_q};
        end else begin
          // On divide-by-zero only hi is re-signed, giving back the original dividend.
          if (neg_q && !dz_q) lo_d = -lo_q;
          if (neg_hi_q)       hi_d = -hi_q;
        end
      end
`endif

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      dz_q     <= dz_d;
    end
  end

`ifdef MULDIV_SIGNED_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sgn_q    <= 1'b0;
      neg_q    <= 1'b0;
      neg_hi_q <= 1'b0;
    end else begin
      sgn_q    <= sgn_d;
      neg_q    <= neg_d;
      neg_hi_q <= neg_hi_d;
    end
  end
`endif

  assign ready    = (state_q == S_IDLE);
  assign done     = (state_q == S_DONE);
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
`default_nettype wire
